control_unit: RTL and testbench

Instruction-sequencing FSM for the simple CPU datapath. It latches an instruction word from `din` and steps through up to four timesteps (T0–T3). In each timestep it drives the bus-select controls (`din_en`, `gout`, `rout`) into the bus multiplexer, and the load enables into the register file, A register, G register and ALU. It sits directly upstream of the bus multiplexer and produces every control input that block consumes.

---
 rtl/control_unit.sv | 140 ++++++++++++++
 tb/tb_control_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: instruction-sequencing FSM for the simple 16-bit CPU datapath.
// It fetches a 9-bit instruction (op/rx/ry) from din in T0, then walks T1..T3
// and drives the bus-mux selects and the register/A/G load enables.
module control_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        run,
  input  logic [15:0] din,
  output logic        din_en,
  output logic        gout,
  output logic [2:0]  rout,
  output logic [7:0]  rin,
  output logic        ain,
  output logic        gin,
  output logic        addsub,
  output logic        irin,
  output logic        done
);

  // Timestep encoding; T0 doubles as the idle/fetch state.
  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [2:0] OpMv  = 3'b000;
  localparam logic [2:0] OpMvi = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b011;

  state_t     state_q, state_d;
  logic [8:0] ir_q, ir_d;

  logic [2:0] op;
  logic [2:0] rx;
  logic [2:0] ry;
  logic [7:0] rxOneHot;
  logic       isAddSub;
  logic       unusedDinBits;

  // The low seven bits of the instruction word carry no meaning.
  assign unusedDinBits = ^din[6:0];

  // Field split of the held instruction and the one-hot destination decode.
  assign op       = ir_q[8:6];
  assign rx       = ir_q[5:3];
  assign ry       = ir_q[2:0];
  assign rxOneHot = 8'b0000_0001 << rx;
  assign isAddSub = (op == OpAdd) || (op == OpSub);

  // State and instruction register; reset returns to fetch with a cleared IR.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= T0;
      ir_q    <= 9'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next state and control outputs; everything is held low while in reset so
  // an aborted instruction can never emit a stray load enable or done pulse.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    din_en  = 1'b0;
    gout    = 1'b0;
    rout    = 3'b000;
    rin     = 8'h00;
    ain     = 1'b0;
    gin     = 1'b0;
    addsub  = 1'b0;
    irin    = 1'b0;
    done    = 1'b0;

    if (resetn) begin
      case (state_q)
        T0: begin
          irin = run;
          if (run) begin
            ir_d    = din[15:7];
            state_d = T1;
          end
        end

        T1: begin
          case (op)
            OpMv: begin
              rout    = ry;
              rin     = rxOneHot;
              done    = 1'b1;
              state_d = T0;
            end
            OpMvi: begin
              din_en  = 1'b1;
              rin     = rxOneHot;
              done    = 1'b1;
              state_d = T0;
            end
            OpAdd, OpSub: begin
              rout    = rx;
              ain     = 1'b1;
              state_d = T2;
            end
            default: begin
              done    = 1'b1;
              state_d = T0;
            end
          endcase
        end

        T2: begin
          if (isAddSub) begin
            rout    = ry;
            gin     = 1'b1;
            addsub  = (op == OpSub);
            state_d = T3;
          end else begin
            state_d = T0;
          end
        end

        T3: begin
          gout    = 1'b1;
          rin     = rxOneHot;
          done    = 1'b1;
          state_d = T0;
        end

        default: begin
          state_d = T0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed test of the control_unit sequencer. Inputs are
// changed 2 time units after each rising edge and outputs checked 1 unit later.
`timescale 1ns/1ps
module tb_control_unit;

  logic        clk;
  logic        resetn;
  logic        run;
  logic [15:0] din;
  logic        din_en;
  logic        gout;
  logic [2:0]  rout;
  logic [7:0]  rin;
  logic        ain;
  logic        gin;
  logic        addsub;
  logic        irin;
  logic        done;

  int assertCount = 0;
  int failCount   = 0;

  control_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .run    (run),
    .din    (din),
    .din_en (din_en),
    .gout   (gout),
    .rout   (rout),
    .rin    (rin),
    .ain    (ain),
    .gin    (gin),
    .addsub (addsub),
    .irin   (irin),
    .done   (done)
  );

  // 10 ns free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends even if the sequence stalls.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Pack the expected control word in the same order as the observed one.
  function automatic logic [17:0] pk(input logic de, input logic go,
                                     input logic [2:0] ro, input logic [7:0] ri,
                                     input logic a, input logic g,
                                     input logic as, input logic ir,
                                     input logic dn);
    pk = {de, go, ro, ri, a, g, as, ir, dn};
  endfunction

  // Compare all outputs at once against the hand-computed control word.
  task automatic checkOutput(input string tag, input logic [17:0] expected);
    logic [17:0] observed;
    #1;
    observed = {din_en, gout, rout, rin, ain, gin, addsub, irin, done};
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %05h expected %05h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [15:0] d);
    run = r;
    din = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  localparam logic [17:0] Zero = 18'd0;

  initial begin
    // Reset held with run high: nothing may move and irin must stay low.
    resetn = 1'b0;
    applyStimulus(1'b1, 16'h2400);
    #2;
    checkOutput("reset_a", Zero);
    tick();
    checkOutput("reset_b", Zero);
    tick();
    checkOutput("reset_c", Zero);

    // Release mid-cycle: T0 with run=1 fetches immediately.
    resetn = 1'b1;
    checkOutput("t0_irin_after_reset", pk(0,0,3'b000,8'h00,0,0,0,1,1'b0));

    // mvi R1,#5
    tick();
    applyStimulus(1'b0, 16'h0005);
    checkOutput("mvi_t1", pk(1,0,3'b000,8'h02,0,0,0,0,1));
    tick();
    checkOutput("mvi_back_t0", Zero);

    // mv R2<-R1
    applyStimulus(1'b1, 16'h0880);
    checkOutput("mv_t0", pk(0,0,3'b000,8'h00,0,0,0,1,0));
    tick();
    applyStimulus(1'b0, 16'h0000);
    checkOutput("mv_t1", pk(0,0,3'b001,8'h04,0,0,0,0,1));
    tick();

    // sub R1<-R1-R2
    applyStimulus(1'b1, 16'h6500);
    checkOutput("sub_t0", pk(0,0,3'b000,8'h00,0,0,0,1,0));
    tick();
    applyStimulus(1'b0, 16'h0000);
    checkOutput("sub_t1", pk(0,0,3'b001,8'h00,1,0,0,0,0));
    tick();
    checkOutput("sub_t2", pk(0,0,3'b010,8'h00,0,1,1,0,0));
    tick();
    checkOutput("sub_t3", pk(0,1,3'b000,8'h02,0,0,0,0,1));
    tick();
    checkOutput("sub_back_t0", Zero);

    // Reserved opcode behaves as a NOP with done only.
    applyStimulus(1'b1, 16'hE000);
    checkOutput("nop_t0", pk(0,0,3'b000,8'h00,0,0,0,1,0));
    tick();
    applyStimulus(1'b0, 16'h0000);
    checkOutput("nop_t1", pk(0,0,3'b000,8'h00,0,0,0,0,1));
    tick();

    // add R3,R3 with run held high; a changed din must not be re-fetched
    // until the sequencer returns to T0.
    applyStimulus(1'b1, 16'h4D80);
    checkOutput("add_t0", pk(0,0,3'b000,8'h00,0,0,0,1,0));
    tick();
    applyStimulus(1'b1, 16'hE000);
    checkOutput("add_t1_run_held", pk(0,0,3'b011,8'h00,1,0,0,0,0));
    tick();
    checkOutput("add_t2_run_held", pk(0,0,3'b011,8'h00,0,1,0,0,0));
    tick();
    checkOutput("add_t3_run_held", pk(0,1,3'b000,8'h08,0,0,0,0,1));
    tick();
    checkOutput("b2b_t0_fetch", pk(0,0,3'b000,8'h00,0,0,0,1,0));
    tick();
    applyStimulus(1'b0, 16'h0000);
    checkOutput("b2b_nop_t1", pk(0,0,3'b000,8'h00,0,0,0,0,1));
    tick();
    checkOutput("b2b_back_t0", Zero);

    // Mid-instruction reset during T2 of add R3,R3.
    applyStimulus(1'b1, 16'h4D80);
    tick();
    applyStimulus(1'b0, 16'h0000);
    tick();
    checkOutput("abort_t2", pk(0,0,3'b011,8'h00,0,1,0,0,0));
    resetn = 1'b0;
    checkOutput("abort_reset_now", Zero);
    tick();
    checkOutput("abort_reset_held", Zero);
    resetn = 1'b1;
    checkOutput("abort_release_t0", Zero);
    tick();
    checkOutput("abort_no_t3", Zero);

    // Normal operation resumes from T0.
    applyStimulus(1'b1, 16'h0880);
    checkOutput("resume_t0", pk(0,0,3'b000,8'h00,0,0,0,1,0));
    tick();
    applyStimulus(1'b0, 16'h0000);
    checkOutput("resume_mv_t1", pk(0,0,3'b001,8'h04,0,0,0,0,1));
    tick();
    checkOutput("resume_back_t0", Zero);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
